// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects the board KEY/SW pins
// ahead of the buttons/switches PIO inputs. It also keeps sticky per-button press
// flags that software clears by writing 1 to flag_clr.
module input_conditioner #(
    parameter int N_BTN           = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [N_BTN-1:0] key_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_flags,
    input  logic [N_BTN-1:0] flag_clr,
    output logic [N_SW-1:0]  sw_level,
    output logic             sw_change
);

    localparam int NB = N_BTN + N_SW;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Buttons are turned active-high before synchronising, so every stage resets to "released".
    logic [N_BTN-1:0] key_act;
    logic [NB-1:0]    raw_all;
    logic [NB-1:0]    level_bus;
    logic [NB-1:0]    upd_bus;

    assign key_act = BTN_ACTIVE_LOW ? ~key_raw : key_raw;
    assign raw_all = {sw_raw, key_act};

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [CW-1:0]          cnt_q, cnt_d;
            logic                   lvl_q, lvl_d;
            logic                   upd;
            logic                   s;

            assign s = sync_q[SYNC_STAGES-1];

            // Shift the synchroniser and count how long s has disagreed with the accepted level.
            always_comb begin
                sync_d = {sync_q[SYNC_STAGES-2:0], raw_all[gi]};
                cnt_d  = cnt_q;
                lvl_d  = lvl_q;
                upd    = 1'b0;
                if (s == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    lvl_d = s;
                    cnt_d = '0;
                    upd   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Per-bit synchroniser, debounce counter and accepted level.
            always_ff @(posedge clk_clk) begin
                if (!reset_reset_n) begin
                    sync_q <= '0;
                    cnt_q  <= '0;
                    lvl_q  <= 1'b0;
                end else begin
                    sync_q <= sync_d;
                    cnt_q  <= cnt_d;
                    lvl_q  <= lvl_d;
                end
            end

            assign level_bus[gi] = lvl_q;
            assign upd_bus[gi]   = upd;
        end
    endgenerate

    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] flags_q, flags_d;
    logic             sw_change_q, sw_change_d;

    // An update flips the level, so the pre-update level tells press from release.
    // Setting a flag takes priority over clearing it on the same edge.
    always_comb begin
        press_d     = upd_bus[N_BTN-1:0] & ~level_bus[N_BTN-1:0];
        release_d   = upd_bus[N_BTN-1:0] &  level_bus[N_BTN-1:0];
        flags_d     = (flags_q & ~flag_clr) | press_d;
        sw_change_d = |upd_bus[NB-1:N_BTN];
    end

    // Pulses and flags are registered on the same edge as the level they describe.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            press_q     <= '0;
            release_q   <= '0;
            flags_q     <= '0;
            sw_change_q <= 1'b0;
        end else begin
            press_q     <= press_d;
            release_q   <= release_d;
            flags_q     <= flags_d;
            sw_change_q <= sw_change_d;
        end
    end

    assign btn_level   = level_bus[N_BTN-1:0];
    assign sw_level    = level_bus[NB-1:N_BTN];
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_flags   = flags_q;
    assign sw_change   = sw_change_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with an 8-cycle debounce and a 2-stage synchroniser.
module tb_input_conditioner;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n;
    logic [3:0] key_raw;
    logic [9:0] sw_raw;
    logic [3:0] flag_clr;
    logic [3:0] btn_level, btn_press, btn_release, btn_flags;
    logic [9:0] sw_level;
    logic       sw_change;

    int n_vec = 0;
    int n_err = 0;

    input_conditioner #(
        .N_BTN(4), .N_SW(10), .DEBOUNCE_CYCLES(8), .SYNC_STAGES(2), .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .key_raw(key_raw), .sw_raw(sw_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_flags(btn_flags), .flag_clr(flag_clr),
        .sw_level(sw_level), .sw_change(sw_change)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] key;
        logic [9:0] sw;
        logic [3:0] clr;
        int         cyc;
        logic [3:0] e_lvl, e_prs, e_rel, e_flg;
        logic [9:0] e_swl;
        logic       e_swc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic [3:0] key, input logic [9:0] sw,
                       input logic [3:0] clr, input int cyc,
                       input logic [3:0] e_lvl, input logic [3:0] e_prs,
                       input logic [3:0] e_rel, input logic [3:0] e_flg,
                       input logic [9:0] e_swl, input logic e_swc);
        vec_t v;
        v.rst_n = rst_n; v.key = key; v.sw = sw; v.clr = clr; v.cyc = cyc;
        v.e_lvl = e_lvl; v.e_prs = e_prs; v.e_rel = e_rel; v.e_flg = e_flg;
        v.e_swl = e_swl; v.e_swc = e_swc;
        vecs.push_back(v);
    endtask

    // One clock edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " btn_level"},   32'(btn_level),   32'(v.e_lvl));
        check({tag, " btn_press"},   32'(btn_press),   32'(v.e_prs));
        check({tag, " btn_release"}, 32'(btn_release), 32'(v.e_rel));
        check({tag, " btn_flags"},   32'(btn_flags),   32'(v.e_flg));
        check({tag, " sw_level"},    32'(sw_level),    32'(v.e_swl));
        check({tag, " sw_change"},   32'(sw_change),   32'(v.e_swc));
    endtask

    initial begin
        int pulses, pulse_t;
        logic any_pulse;

        reset_reset_n = 1'b0;
        key_raw  = 4'hF;
        sw_raw   = 10'h000;
        flag_clr = 4'h0;

        //   rst key    sw      clr  cyc  lvl   prs   rel   flg   swl     swc
        add(0, 4'hF, 10'h000, 4'h0, 2,  4'h0, 4'h0, 4'h0, 4'h0, 10'h000, 0); // reset state
        add(1, 4'hF, 10'h000, 4'h0, 3,  4'h0, 4'h0, 4'h0, 4'h0, 10'h000, 0); // idle
        add(1, 4'hE, 10'h000, 4'h0, 9,  4'h0, 4'h0, 4'h0, 4'h0, 10'h000, 0); // key0 pressed, 9 edges
        add(1, 4'hE, 10'h000, 4'h0, 1,  4'h1, 4'h1, 4'h0, 4'h1, 10'h000, 0); // 10th edge: press
        add(1, 4'hE, 10'h000, 4'h0, 1,  4'h1, 4'h0, 4'h0, 4'h1, 10'h000, 0); // pulse one cycle
        add(1, 4'hE, 10'h000, 4'h0, 5,  4'h1, 4'h0, 4'h0, 4'h1, 10'h000, 0); // held
        add(1, 4'hF, 10'h000, 4'h0, 9,  4'h1, 4'h0, 4'h0, 4'h1, 10'h000, 0); // release, 9 edges
        add(1, 4'hF, 10'h000, 4'h0, 1,  4'h0, 4'h0, 4'h1, 4'h1, 10'h000, 0); // release pulse, flag kept
        add(1, 4'hF, 10'h000, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h1, 10'h000, 0);
        add(1, 4'hE, 10'h000, 4'h0, 9,  4'h0, 4'h0, 4'h0, 4'h1, 10'h000, 0); // second press pending
        add(1, 4'hE, 10'h000, 4'h1, 1,  4'h1, 4'h1, 4'h0, 4'h1, 10'h000, 0); // clear+press: set wins
        add(1, 4'hE, 10'h000, 4'h1, 1,  4'h1, 4'h0, 4'h0, 4'h0, 10'h000, 0); // clear alone
        add(1, 4'hE, 10'h000, 4'h0, 1,  4'h1, 4'h0, 4'h0, 4'h0, 10'h000, 0);
        add(1, 4'hF, 10'h000, 4'h0, 10, 4'h0, 4'h0, 4'h1, 4'h0, 10'h000, 0); // release
        add(1, 4'hF, 10'h3FF, 4'h0, 9,  4'h0, 4'h0, 4'h0, 4'h0, 10'h000, 0); // all switches on
        add(1, 4'hF, 10'h3FF, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0, 10'h3FF, 1); // single change pulse
        add(1, 4'hF, 10'h3FF, 4'h0, 1,  4'h0, 4'h0, 4'h0, 4'h0, 10'h3FF, 0);
        add(1, 4'hF, 10'h000, 4'h0, 10, 4'h0, 4'h0, 4'h0, 4'h0, 10'h000, 1); // all switches off
        add(1, 4'h0, 10'h000, 4'h0, 10, 4'hF, 4'hF, 4'h0, 4'hF, 10'h000, 0); // all keys at once
        add(1, 4'h0, 10'h000, 4'h0, 1,  4'hF, 4'h0, 4'h0, 4'hF, 10'h000, 0);
        add(1, 4'h0, 10'h000, 4'hF, 1,  4'hF, 4'h0, 4'h0, 4'h0, 10'h000, 0); // clear all flags
        add(1, 4'hF, 10'h000, 4'h0, 10, 4'h0, 4'h0, 4'hF, 4'h0, 10'h000, 0); // release all

        foreach (vecs[i]) begin
            reset_reset_n = vecs[i].rst_n;
            key_raw       = vecs[i].key;
            sw_raw        = vecs[i].sw;
            flag_clr      = vecs[i].clr;
            tick(vecs[i].cyc);
            $display("row %0d: key=%h sw=%h clr=%h lvl=%h prs=%h rel=%h flg=%h swl=%h swc=%b",
                     i, key_raw, sw_raw, flag_clr, btn_level, btn_press, btn_release,
                     btn_flags, sw_level, sw_change);
            check_all($sformatf("row%0d", i), vecs[i]);
        end
        flag_clr = 4'h0;

        // Bounce on key1: low 5, high 1, low 20 -> one press 10 edges after the final low.
        key_raw = 4'hD;
        tick(5);
        key_raw = 4'hF;
        tick(1);
        check("bounce no early level", 32'(btn_level), 32'h0);
        key_raw = 4'hD;
        pulses = 0;
        pulse_t = 0;
        for (int t = 1; t <= 20; t++) begin
            tick(1);
            if (btn_press[1]) begin
                pulses++;
                pulse_t = t;
            end
        end
        $display("bounce: pulses=%0d at edge %0d lvl=%h flg=%h", pulses, pulse_t, btn_level, btn_flags);
        check("bounce pulse count", 32'(pulses), 32'd1);
        check("bounce pulse edge", 32'(pulse_t), 32'd10);
        check("bounce level", 32'(btn_level), 32'h2);
        check("bounce flags", 32'(btn_flags), 32'h2);

        // All keys held through reset -> fresh presses 10 edges after release.
        key_raw = 4'h0;
        reset_reset_n = 1'b0;
        tick(2);
        check("held reset level", 32'(btn_level), 32'h0);
        check("held reset flags", 32'(btn_flags), 32'h0);
        reset_reset_n = 1'b1;
        tick(9);
        check("held edge9 level", 32'(btn_level), 32'h0);
        tick(1);
        $display("held through reset: lvl=%h prs=%h", btn_level, btn_press);
        check("held edge10 level", 32'(btn_level), 32'hF);
        check("held edge10 press", 32'(btn_press), 32'hF);
        tick(1);
        check("held press one cycle", 32'(btn_press), 32'h0);

        // Reset in the middle of a release debounce: outputs clear, nothing pulses afterwards.
        key_raw = 4'hF;
        tick(5);
        reset_reset_n = 1'b0;
        tick(1);
        $display("mid-debounce reset: lvl=%h prs=%h rel=%h flg=%h", btn_level, btn_press,
                 btn_release, btn_flags);
        check("mid reset level", 32'(btn_level), 32'h0);
        check("mid reset release", 32'(btn_release), 32'h0);
        check("mid reset flags", 32'(btn_flags), 32'h0);
        reset_reset_n = 1'b1;
        any_pulse = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick(1);
            if ((|btn_press) || (|btn_release) || sw_change || (|btn_level)) any_pulse = 1'b1;
        end
        check("post reset quiet", 32'(any_pulse), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
